// File: rtl/hps_pio_responder.sv
// Avalon-MM responder for board keys, switches and LEDs on the HPS lightweight bridge.
// Synchronizes and debounces pins, captures key presses, and raises a maskable level IRQ.
module hps_pio_responder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int KEY_W           = 2,
  parameter int SW_W            = 4,
  parameter int LED_W           = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [KEY_W-1:0] keys_in,
  input  logic [SW_W-1:0]  switches_in,
  output logic [LED_W-1:0] leds_out,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  logic [KEY_W-1:0] key_meta, key_sync, key_db, key_db_nxt;
  logic [SW_W-1:0]  sw_meta, sw_sync, sw_db, sw_db_nxt;
  logic [CW-1:0]    key_cnt [KEY_W];
  logic [CW-1:0]    key_cnt_nxt [KEY_W];
  logic [CW-1:0]    sw_cnt [SW_W];
  logic [CW-1:0]    sw_cnt_nxt [SW_W];
  logic [KEY_W-1:0] edge_cap, edge_nxt, irq_mask, w1c_bits;
  logic [31:0]      rd_mux;
  logic             wr_led, wr_edge, wr_mask;

  // One debounce step: returns {next db, next counter}; a mismatch must persist for the full window.
  function automatic logic [CW:0] debounce_step(input logic s, input logic d, input logic [CW-1:0] c);
    if (s == d) begin
      return {d, CNT_ZERO};
    end else if (c == CNT_LAST) begin
      return {s, CNT_ZERO};
    end else begin
      return {d, c + CW'(1)};
    end
  endfunction

  always_comb begin
    key_db_nxt = key_db;
    sw_db_nxt  = sw_db;
    for (int i = 0; i < KEY_W; i++) begin
      {key_db_nxt[i], key_cnt_nxt[i]} = debounce_step(key_sync[i], key_db[i], key_cnt[i]);
    end
    for (int j = 0; j < SW_W; j++) begin
      {sw_db_nxt[j], sw_cnt_nxt[j]} = debounce_step(sw_sync[j], sw_db[j], sw_cnt[j]);
    end
  end

  assign wr_led  = avs_write && (avs_address == 3'd2);
  assign wr_edge = avs_write && (avs_address == 3'd3);
  assign wr_mask = avs_write && (avs_address == 3'd4);

  // A press landing on the same edge as a W1C keeps the bit set.
  always_comb begin
    if (wr_edge) begin
      w1c_bits = avs_writedata[KEY_W-1:0];
    end else begin
      w1c_bits = {KEY_W{1'b0}};
    end
    edge_nxt = (edge_cap & ~w1c_bits) | (key_db & ~key_db_nxt);
  end

  always_comb begin
    rd_mux = 32'h0000_0000;
    case (avs_address)
      3'd0:    rd_mux[KEY_W-1:0] = ~key_db;
      3'd1:    rd_mux[SW_W-1:0]  = sw_db;
      3'd2:    rd_mux[LED_W-1:0] = leds_out;
      3'd3:    rd_mux[KEY_W-1:0] = edge_cap;
      3'd4:    rd_mux[KEY_W-1:0] = irq_mask;
      default: rd_mux = 32'h0000_0000;
    endcase
  end

  // Input synchronizers and debouncers; keys idle high (released).
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      key_meta <= {KEY_W{1'b1}};
      key_sync <= {KEY_W{1'b1}};
      key_db   <= {KEY_W{1'b1}};
      sw_meta  <= {SW_W{1'b0}};
      sw_sync  <= {SW_W{1'b0}};
      sw_db    <= {SW_W{1'b0}};
      for (int i = 0; i < KEY_W; i++) key_cnt[i] <= CNT_ZERO;
      for (int j = 0; j < SW_W; j++)  sw_cnt[j]  <= CNT_ZERO;
    end else begin
      key_meta <= keys_in;
      key_sync <= key_meta;
      key_db   <= key_db_nxt;
      sw_meta  <= switches_in;
      sw_sync  <= sw_meta;
      sw_db    <= sw_db_nxt;
      for (int i = 0; i < KEY_W; i++) key_cnt[i] <= key_cnt_nxt[i];
      for (int j = 0; j < SW_W; j++)  sw_cnt[j]  <= sw_cnt_nxt[j];
    end
  end

  // Register file, read data and interrupt.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      leds_out     <= {LED_W{1'b0}};
      edge_cap     <= {KEY_W{1'b0}};
      irq_mask     <= {KEY_W{1'b0}};
      avs_readdata <= 32'h0000_0000;
      irq          <= 1'b0;
    end else begin
      edge_cap <= edge_nxt;
      irq      <= |(edge_cap & irq_mask);
      if (wr_led) begin
        leds_out <= avs_writedata[LED_W-1:0];
      end
      if (wr_mask) begin
        irq_mask <= avs_writedata[KEY_W-1:0];
      end
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
    end
  end

endmodule

// File: tb/tb_hps_pio_responder.sv
// Directed bench for hps_pio_responder with a 4-cycle debounce window.
module tb_hps_pio_responder;
  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic [1:0]  keys_in = 2'b11;
  logic [3:0]  switches_in = 4'h0;
  logic [7:0]  leds_out;
  logic [2:0]  avs_address = 3'd0;
  logic        avs_read = 1'b0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = 32'h0;
  logic [31:0] avs_readdata;
  logic        irq;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;

  hps_pio_responder #(.DEBOUNCE_CYCLES(4), .KEY_W(2), .SW_W(4), .LED_W(8)) dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset), .keys_in(keys_in),
    .switches_in(switches_in), .leds_out(leds_out), .avs_address(avs_address),
    .avs_read(avs_read), .avs_write(avs_write), .avs_writedata(avs_writedata),
    .avs_readdata(avs_readdata), .irq(irq)
  );

  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every helper starts and ends 1 time unit after a rising edge.
  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] v);
    avs_address = a; avs_writedata = v; avs_write = 1'b1;
    cycles(1);
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] v);
    avs_address = a; avs_read = 1'b1;
    cycles(1);
    avs_read = 1'b0;
    v = avs_readdata;
  endtask

  task automatic test_reset;
    cycles(3);
    checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL reset_readdata got=%h exp=%h", avs_readdata, 32'h0); end
    checks++; if (leds_out !== 8'h00) begin failures++; $display("FAIL reset_leds got=%h exp=%h", leds_out, 8'h00); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", irq); end
    reset_reset = 1'b0;
    cycles(1);
    rd(3'd0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_keys got=%h exp=0", d); end
    rd(3'd1, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_sw got=%h exp=0", d); end
    rd(3'd3, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_edge got=%h exp=0", d); end
    rd(3'd4, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", d); end
  endtask

  task automatic test_leds;
    wr(3'd2, 32'h0000_00A5);
    checks++; if (leds_out !== 8'hA5) begin failures++; $display("FAIL leds_write got=%h exp=a5", leds_out); end
    rd(3'd2, d); checks++; if (d !== 32'h0000_00A5) begin failures++; $display("FAIL leds_read got=%h exp=a5", d); end
    wr(3'd5, 32'hFFFF_FFFF);
    rd(3'd5, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL unused_addr got=%h exp=0", d); end
    wr(3'd0, 32'hFFFF_FFFF);
    rd(3'd0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL ro_keys_write got=%h exp=0", d); end
    // Read and write of the same register together: read sees the old value.
    avs_address = 3'd2; avs_writedata = 32'h0000_003C; avs_read = 1'b1; avs_write = 1'b1;
    cycles(1);
    avs_read = 1'b0; avs_write = 1'b0;
    checks++; if (avs_readdata !== 32'h0000_00A5) begin failures++; $display("FAIL rdwr_old got=%h exp=a5", avs_readdata); end
    checks++; if (leds_out !== 8'h3C) begin failures++; $display("FAIL rdwr_new got=%h exp=3c", leds_out); end
    cycles(2);
    checks++; if (avs_readdata !== 32'h0000_00A5) begin failures++; $display("FAIL readdata_hold got=%h exp=a5", avs_readdata); end
  endtask

  task automatic test_glitch;
    keys_in[0] = 1'b0;
    cycles(3);
    keys_in[0] = 1'b1;
    cycles(10);
    rd(3'd0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_keys got=%h exp=0", d); end
    rd(3'd3, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL glitch_edge got=%h exp=0", d); end
  endtask

  task automatic test_press;
    // Continuous reads of KEYS: debounced value moves on edge 6, readdata shows it one edge later.
    keys_in[0] = 1'b0;
    avs_address = 3'd0; avs_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL press_early edge=%0d got=%h exp=0", k, avs_readdata); end
    end
    cycles(1);
    checks++; if (avs_readdata !== 32'h1) begin failures++; $display("FAIL press_keys got=%h exp=1", avs_readdata); end
    avs_address = 3'd3;
    cycles(1);
    avs_read = 1'b0;
    checks++; if (avs_readdata !== 32'h1) begin failures++; $display("FAIL press_edge got=%h exp=1", avs_readdata); end
    cycles(2);
    keys_in[0] = 1'b1;
    cycles(8);
    rd(3'd0, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL release_keys got=%h exp=0", d); end
    rd(3'd3, d); checks++; if (d !== 32'h1) begin failures++; $display("FAIL release_edge got=%h exp=1", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL unmasked_irq got=%b exp=0", irq); end
  endtask

  task automatic test_irq;
    wr(3'd4, 32'h1);
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_lag got=%b exp=0", irq); end
    cycles(1);
    checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%b exp=1", irq); end
    wr(3'd3, 32'h1);
    rd(3'd3, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL w1c_edge got=%h exp=0", d); end
    checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%b exp=0", irq); end
  endtask

  task automatic test_w1c_race;
    keys_in[1] = 1'b0;
    cycles(5);
    // W1C of bit 1 sampled on edge 6, the edge where key 1's debounced value falls.
    wr(3'd3, 32'h2);
    rd(3'd3, d); checks++; if (d !== 32'h2) begin failures++; $display("FAIL race_set_wins got=%h exp=2", d); end
    rd(3'd0, d); checks++; if (d !== 32'h2) begin failures++; $display("FAIL race_keys got=%h exp=2", d); end
    keys_in[1] = 1'b1;
    cycles(8);
    wr(3'd3, 32'h2);
    rd(3'd3, d); checks++; if (d !== 32'h0) begin failures++; $display("FAIL plain_w1c got=%h exp=0", d); end
  endtask

  task automatic test_reset_mid;
    switches_in = 4'hC;
    cycles(4);
    reset_reset = 1'b1;
    cycles(1);
    reset_reset = 1'b0;
    checks++; if (leds_out !== 8'h00) begin failures++; $display("FAIL midreset_leds got=%h exp=0", leds_out); end
    avs_address = 3'd1; avs_read = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cycles(1);
      checks++; if (avs_readdata !== 32'h0) begin failures++; $display("FAIL midreset_sw_early edge=%0d got=%h exp=0", k, avs_readdata); end
    end
    cycles(1);
    avs_read = 1'b0;
    checks++; if (avs_readdata !== 32'h0000_000C) begin failures++; $display("FAIL midreset_sw got=%h exp=c", avs_readdata); end
  endtask

  initial begin
    #1;
    test_reset;
    test_leds;
    test_glitch;
    test_press;
    test_irq;
    test_w1c_race;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
